// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of independent registered SR latches with invalid-input tracking
module sr_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S_n,
  input  logic [WIDTH-1:0] R_n,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] q_next;
  logic             any_inv;

  assign set_v   = ~S_n & R_n;
  assign clr_v   = S_n & ~R_n;
  assign inv     = ~S_n & ~R_n;
  assign any_inv = |inv;
  assign Q_n     = ~Q;

  // Invalid bits have set_v = clr_v = 0, so they carry Q into the mode stage untouched.
  always_comb begin
    q_next = (Q | set_v) & ~clr_v;
    case (MODE)
      1:       q_next = q_next | inv;
      2:       q_next = q_next & ~inv;
      3:       q_next = q_next ^ inv;
      default: q_next = q_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q       <= RST_VAL;
      chg     <= '0;
      err     <= '0;
      err_cnt <= '0;
    end else begin
      Q   <= q_next;
      chg <= q_next ^ Q;
      // A fresh invalid event outranks a clear issued in the same cycle.
      if (any_inv) begin
        err <= err_clr ? inv : (err | inv);
        if (err_clr)
          err_cnt <= CNT_W'(1);
        else if (!(&err_cnt))
          err_cnt <= err_cnt + CNT_W'(1);
      end else if (err_clr) begin
        err     <= '0;
        err_cnt <= '0;
      end
    end
  end

endmodule
